nn_param_loader: RTL and testbench

Streams trained weights and biases from a 32-bit host word stream into the neuron array. It parses a header-plus-payload packet format and drives the shared neuron configuration bus: weightValid/weightValue, biasValid/biasValue and config_layer_num/config_neuron_num. Each neuron latches only the words whose layer/neuron numbers match its own. It sits between the host DMA/AXI-stream bridge and every neuron instance, and is the producer end of the bus the neurons consume.

---
 rtl/nn_param_loader_pkg.sv | 45 ++++
 rtl/nn_param_loader_if.sv | 34 +++
 rtl/nn_param_loader.sv | 132 +++++++++++++
 tb/tb_nn_param_loader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_param_loader_pkg.sv
// nn_param_loader_pkg
// Shared definitions for the neuron parameter loader:
//   - bit positions of the header word fields
//   - payload kind encodings (weight / bias)
//   - loader state encodings
//   - a helper that splits a raw 32-bit word into header fields
package nn_param_loader_pkg;

  // Header word layout: [31] kind, [30:24] layer, [23:16] neuron, [15:0] count
  localparam int KIND_BIT   = 31;
  localparam int LAYER_MSB  = 30;
  localparam int LAYER_LSB  = 24;
  localparam int NEURON_MSB = 23;
  localparam int NEURON_LSB = 16;
  localparam int COUNT_MSB  = 15;
  localparam int COUNT_LSB  = 0;

  typedef enum logic {
    KIND_WEIGHT = 1'b0,
    KIND_BIAS   = 1'b1
  } kind_t;

  typedef enum logic [1:0] {
    HDR     = 2'd0,
    PAYLOAD = 2'd1,
    DROP    = 2'd2
  } state_t;

  typedef struct packed {
    kind_t       kind;
    logic [6:0]  layer;
    logic [7:0]  neuron;
    logic [15:0] count;
  } header_t;

  function automatic header_t decode_header(input logic [31:0] word);
    header_t h;
    h.kind   = kind_t'(word[KIND_BIT]);
    h.layer  = word[LAYER_MSB:LAYER_LSB];
    h.neuron = word[NEURON_MSB:NEURON_LSB];
    h.count  = word[COUNT_MSB:COUNT_LSB];
    return h;
  endfunction

endpackage

// File: rtl/nn_param_loader_if.sv
// nn_param_loader_if
// Host word stream plus the shared neuron configuration bus.
//   s_data/s_valid/s_ready        : host -> loader word stream
//   weightValid/weightValue       : weight strobe and word to the neurons
//   biasValid/biasValue           : bias strobe and word to the neurons
//   config_layer_num/neuron_num   : target neuron for the current strobes
// Modports:
//   master : host/observer side (drives the stream, watches the bus)
//   slave  : the loader (consumes the stream, drives the bus)
interface nn_param_loader_if;

  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        weightValid;
  logic [31:0] weightValue;
  logic        biasValid;
  logic [31:0] biasValue;
  logic [31:0] config_layer_num;
  logic [31:0] config_neuron_num;

  modport master (
    output s_data, s_valid,
    input  s_ready, weightValid, weightValue, biasValid, biasValue,
           config_layer_num, config_neuron_num
  );

  modport slave (
    input  s_data, s_valid,
    output s_ready, weightValid, weightValue, biasValid, biasValue,
           config_layer_num, config_neuron_num
  );

endinterface

// File: rtl/nn_param_loader.sv
// nn_param_loader
// Parses a header-plus-payload host word stream and drives the shared neuron
// configuration bus. Each payload word becomes a one-cycle weight or bias
// strobe tagged with the target layer/neuron from its header.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : host stream in, neuron configuration bus out
//   busy         : a packet is in progress
//   error        : sticky flag, a header with an out-of-range target was seen
//   words_loaded : number of payload words emitted as strobes (wraps)
module nn_param_loader
  import nn_param_loader_pkg::*;
#(
  parameter int numLayers  = 4,
  parameter int maxNeurons = 30
) (
  input  logic               clk,
  input  logic               rst,
  nn_param_loader_if.slave   bus,
  output logic               busy,
  output logic               error,
  output logic [31:0]        words_loaded
);

  localparam logic [31:0] LAYER_LIMIT  = 32'(numLayers);
  localparam logic [31:0] NEURON_LIMIT = 32'(maxNeurons);

  state_t      state;
  logic [15:0] remaining;
  kind_t       kind;
  logic [6:0]  stage_layer;
  logic [7:0]  stage_neuron;
  logic        stage_apply;

  logic    accept;
  header_t hdr;
  logic    bad_target;

  assign accept     = bus.s_valid & bus.s_ready;
  assign hdr        = decode_header(bus.s_data);
  assign bad_target = ({25'd0, hdr.layer} >= LAYER_LIMIT) ||
                      ({24'd0, hdr.neuron} >= NEURON_LIMIT);

  // Header fields are staged for one cycle before reaching config_*. The
  // first payload strobe of a packet can never appear earlier than that, so
  // config_* and strobes change on the same edge and the last strobe of a
  // packet is never relabelled by the next packet's header.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= HDR;
      remaining             <= '0;
      kind                  <= KIND_WEIGHT;
      stage_layer           <= '0;
      stage_neuron          <= '0;
      stage_apply           <= 1'b0;
      bus.s_ready           <= 1'b0;
      bus.weightValid       <= 1'b0;
      bus.weightValue       <= '0;
      bus.biasValid         <= 1'b0;
      bus.biasValue         <= '0;
      bus.config_layer_num  <= '0;
      bus.config_neuron_num <= '0;
      busy                  <= 1'b0;
      error                 <= 1'b0;
      words_loaded          <= '0;
    end else begin
      bus.s_ready     <= 1'b1;
      bus.weightValid <= 1'b0;
      bus.biasValid   <= 1'b0;
      stage_apply     <= 1'b0;

      if (stage_apply) begin
        bus.config_layer_num  <= {25'd0, stage_layer};
        bus.config_neuron_num <= {24'd0, stage_neuron};
      end

      case (state)
        HDR: begin
          // A zero-count header is a no-op and leaves config_* untouched.
          if (accept && (hdr.count != 16'd0)) begin
            remaining <= hdr.count;
            busy      <= 1'b1;
            if (bad_target) begin
              error <= 1'b1;
              state <= DROP;
            end else begin
              kind         <= hdr.kind;
              stage_layer  <= hdr.layer;
              stage_neuron <= hdr.neuron;
              stage_apply  <= 1'b1;
              state        <= PAYLOAD;
            end
          end
        end

        PAYLOAD: begin
          if (accept) begin
            if (kind == KIND_BIAS) begin
              bus.biasValid <= 1'b1;
              bus.biasValue <= bus.s_data;
            end else begin
              bus.weightValid <= 1'b1;
              bus.weightValue <= bus.s_data;
            end
            words_loaded <= words_loaded + 32'd1;
            remaining    <= remaining - 16'd1;
            if (remaining == 16'd1) begin
              state <= HDR;
              busy  <= 1'b0;
            end
          end
        end

        DROP: begin
          if (accept) begin
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1) begin
              state <= HDR;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state <= HDR;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nn_param_loader.sv
// tb_nn_param_loader
// Directed bench for nn_param_loader. A negedge monitor records every strobe
// together with the config_* seen alongside it and the cycle it appeared in;
// the directed sequence then compares that record against hand-computed
// expectations.
module tb_nn_param_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic        error;
  logic [31:0] words_loaded;

  nn_param_loader_if bus ();

  nn_param_loader #(
    .numLayers  (4),
    .maxNeurons (30)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .busy         (busy),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        kind;
    logic [31:0] value;
    logic [31:0] layer;
    logic [31:0] neuron;
    int          cyc;
  } strobe_t;

  strobe_t strobe_log[$];
  int      accept_cyc[$];
  int      cyc         = 0;
  int      both_high   = 0;
  int      testsRun    = 0;
  int      testsFailed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture strobes mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (bus.weightValid && bus.biasValid) both_high++;
    if (bus.weightValid)
      strobe_log.push_back('{1'b0, bus.weightValue, bus.config_layer_num,
                             bus.config_neuron_num, cyc});
    else if (bus.biasValid)
      strobe_log.push_back('{1'b1, bus.biasValue, bus.config_layer_num,
                             bus.config_neuron_num, cyc});
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present one word starting at a negedge; returns at the negedge after it
  // is accepted, so back-to-back calls keep s_valid high continuously.
  task automatic applyStimulus(input logic [31:0] word, input bit is_payload);
    int budget = 20;
    while (bus.s_ready !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (bus.s_ready !== 1'b1) checkOutput("s_ready_timeout", bus.s_ready, 32'd1);
    bus.s_data  = word;
    bus.s_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.s_valid = 1'b0;
    if (is_payload) accept_cyc.push_back(cyc);
  endtask

  task automatic idleCycles(input int n);
    bus.s_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic clearLogs();
    strobe_log.delete();
    accept_cyc.delete();
  endtask

  task automatic checkStrobe(input string tag, input int idx, input logic kind,
                             input logic [31:0] value, input logic [31:0] layer,
                             input logic [31:0] neuron);
    if (idx >= strobe_log.size()) begin
      checkOutput({tag, "_present"}, strobe_log.size(), idx + 1);
    end else begin
      checkOutput({tag, "_kind"},   {31'd0, strobe_log[idx].kind}, {31'd0, kind});
      checkOutput({tag, "_value"},  strobe_log[idx].value,  value);
      checkOutput({tag, "_layer"},  strobe_log[idx].layer,  layer);
      checkOutput({tag, "_neuron"}, strobe_log[idx].neuron, neuron);
      if (idx < accept_cyc.size())
        checkOutput({tag, "_latency"}, strobe_log[idx].cyc, accept_cyc[idx]);
    end
  endtask

  task automatic checkResetState(input string pfx);
    checkOutput({pfx, "_s_ready"},      {31'd0, bus.s_ready},     32'd0);
    checkOutput({pfx, "_weightValid"},  {31'd0, bus.weightValid}, 32'd0);
    checkOutput({pfx, "_biasValid"},    {31'd0, bus.biasValid},   32'd0);
    checkOutput({pfx, "_busy"},         {31'd0, busy},            32'd0);
    checkOutput({pfx, "_error"},        {31'd0, error},           32'd0);
    checkOutput({pfx, "_weightValue"},  bus.weightValue,          32'd0);
    checkOutput({pfx, "_biasValue"},    bus.biasValue,            32'd0);
    checkOutput({pfx, "_words_loaded"}, words_loaded,             32'd0);
    checkOutput({pfx, "_cfg_layer"},    bus.config_layer_num,     32'd0);
    checkOutput({pfx, "_cfg_neuron"},   bus.config_neuron_num,    32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    bus.s_data  = '0;
    bus.s_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;

    // Weight packet: layer 1, neuron 5, three words back-to-back
    clearLogs();
    applyStimulus(32'h0105_0003, 1'b0);
    checkOutput("t1_busy_after_hdr", {31'd0, busy}, 32'd1);
    applyStimulus(32'h0000_0011, 1'b1);
    applyStimulus(32'h0000_0022, 1'b1);
    applyStimulus(32'h0000_0033, 1'b1);
    idleCycles(2);
    checkOutput("t1_n_strobes", strobe_log.size(), 32'd3);
    checkStrobe("t1_w0", 0, 1'b0, 32'h11, 32'd1, 32'd5);
    checkStrobe("t1_w1", 1, 1'b0, 32'h22, 32'd1, 32'd5);
    checkStrobe("t1_w2", 2, 1'b0, 32'h33, 32'd1, 32'd5);
    checkOutput("t1_words_loaded", words_loaded, 32'd3);
    checkOutput("t1_busy_after", {31'd0, busy}, 32'd0);

    // Bias packet then weight packet back-to-back
    clearLogs();
    applyStimulus(32'h8209_0001, 1'b0);
    applyStimulus(32'h0000_ABCD, 1'b1);
    applyStimulus(32'h0000_0002, 1'b0);
    applyStimulus(32'h0000_0001, 1'b1);
    applyStimulus(32'h0000_0002, 1'b1);
    idleCycles(2);
    checkOutput("t2_n_strobes", strobe_log.size(), 32'd3);
    checkStrobe("t2_b0", 0, 1'b1, 32'hABCD, 32'd2, 32'd9);
    checkStrobe("t2_w0", 1, 1'b0, 32'h1, 32'd0, 32'd0);
    checkStrobe("t2_w1", 2, 1'b0, 32'h2, 32'd0, 32'd0);
    checkOutput("t2_words_loaded", words_loaded, 32'd6);
    checkOutput("t2_bias_hold", bus.biasValue, 32'hABCD);
    checkOutput("t2_weight_hold", bus.weightValue, 32'h2);

    // Bad layer (4 == numLayers): payload dropped, error sticky
    clearLogs();
    applyStimulus(32'h0400_0002, 1'b0);
    checkOutput("t3_error_rise", {31'd0, error}, 32'd1);
    checkOutput("t3_busy_drop", {31'd0, busy}, 32'd1);
    applyStimulus(32'h0000_DEAD, 1'b0);
    applyStimulus(32'h0000_BEEF, 1'b0);
    idleCycles(2);
    checkOutput("t3_no_strobes", strobe_log.size(), 32'd0);
    checkOutput("t3_busy_after_drop", {31'd0, busy}, 32'd0);
    checkOutput("t3_words_unchanged", words_loaded, 32'd6);
    // Highest legal target (layer 3, neuron 29) still loads
    applyStimulus(32'h031D_0001, 1'b0);
    applyStimulus(32'h0000_0055, 1'b1);
    idleCycles(2);
    checkOutput("t3_n_strobes_valid", strobe_log.size(), 32'd1);
    checkStrobe("t3_w0", 0, 1'b0, 32'h55, 32'd3, 32'd29);
    checkOutput("t3_error_sticky", {31'd0, error}, 32'd1);
    checkOutput("t3_words_loaded", words_loaded, 32'd7);
    // Neuron 30 == maxNeurons is out of range
    clearLogs();
    applyStimulus(32'h001E_0001, 1'b0);
    applyStimulus(32'h0000_0099, 1'b0);
    idleCycles(2);
    checkOutput("t3_bad_neuron_no_strobe", strobe_log.size(), 32'd0);
    checkOutput("t3_bad_neuron_words", words_loaded, 32'd7);

    // count=0 header is a no-op; next word is a header
    clearLogs();
    applyStimulus(32'h0000_0000, 1'b0);
    checkOutput("t4_busy_noop", {31'd0, busy}, 32'd0);
    applyStimulus(32'h8101_0001, 1'b0);
    checkOutput("t4_busy_second", {31'd0, busy}, 32'd1);
    applyStimulus(32'h0000_0077, 1'b1);
    idleCycles(2);
    checkOutput("t4_n_strobes", strobe_log.size(), 32'd1);
    checkStrobe("t4_b0", 0, 1'b1, 32'h77, 32'd1, 32'd1);
    checkOutput("t4_words_loaded", words_loaded, 32'd8);

    // Gapped payload: s_valid 1010 over four words
    clearLogs();
    applyStimulus(32'h0203_0004, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(32'h100 + 32'(i), 1'b1);
      idleCycles(1);
    end
    idleCycles(2);
    checkOutput("t5_n_strobes", strobe_log.size(), 32'd4);
    checkStrobe("t5_w0", 0, 1'b0, 32'h100, 32'd2, 32'd3);
    checkStrobe("t5_w1", 1, 1'b0, 32'h101, 32'd2, 32'd3);
    checkStrobe("t5_w2", 2, 1'b0, 32'h102, 32'd2, 32'd3);
    checkStrobe("t5_w3", 3, 1'b0, 32'h103, 32'd2, 32'd3);
    checkOutput("t5_words_loaded", words_loaded, 32'd12);

    // Reset after 2 of 5 payload words
    applyStimulus(32'h0102_0005, 1'b0);
    applyStimulus(32'h0000_0AAA, 1'b1);
    applyStimulus(32'h0000_0BBB, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkResetState("t6_reset");
    rst = 1'b0;
    clearLogs();
    applyStimulus(32'h0007_0003, 1'b0);
    applyStimulus(32'h0000_00A1, 1'b1);
    applyStimulus(32'h0000_00A2, 1'b1);
    applyStimulus(32'h0000_00A3, 1'b1);
    idleCycles(2);
    checkOutput("t6_n_strobes", strobe_log.size(), 32'd3);
    checkStrobe("t6_w0", 0, 1'b0, 32'hA1, 32'd0, 32'd7);
    checkStrobe("t6_w1", 1, 1'b0, 32'hA2, 32'd0, 32'd7);
    checkStrobe("t6_w2", 2, 1'b0, 32'hA3, 32'd0, 32'd7);
    checkOutput("t6_words_loaded", words_loaded, 32'd3);
    checkOutput("t6_error_clear", {31'd0, error}, 32'd0);

    checkOutput("both_strobes_never", both_high, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
